// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between instruction fetch and
// load/store, with fixed MEM priority and a bounded-starvation override for IF.
module mem_port_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_valid,
  input  logic [31:0]       if_req_addr,
  output logic              if_req_ready,
  output logic              if_resp_valid,
  output logic [31:0]       if_resp_data,
  input  logic              mem_req_valid,
  input  logic              mem_req_we,
  input  logic [31:0]       mem_req_addr,
  input  logic [31:0]       mem_req_wdata,
  output logic              mem_req_ready,
  output logic              mem_resp_valid,
  output logic [31:0]       mem_resp_data,
  input  logic              flush,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [3:0]        starve_cnt
);

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_IF,
    TAG_MEM_RD,
    TAG_MEM_WR
  } tag_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  tag_e        tag_q, tag_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] if_data_q, if_data_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic        starve, if_grant, mem_grant;

  // Byte-offset and high address bits are intentionally dropped (word RAM wraps).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_req_addr[31:ADDR_W+2], if_req_addr[1:0],
                              mem_req_addr[31:ADDR_W+2], mem_req_addr[1:0]};

  // Grants are qualified by rst so every request-side output is 0 during reset.
  always_comb begin
    starve    = (starve_q == MAX_WAIT_C);
    if_grant  = rst & if_req_valid & ~flush & (~mem_req_valid | starve);
    mem_grant = rst & mem_req_valid & ~if_grant;
  end

  assign if_req_ready  = if_grant;
  assign mem_req_ready = mem_grant;
  assign ram_en        = if_grant | mem_grant;
  assign ram_we        = mem_grant & mem_req_we;
  assign ram_wdata     = rst ? mem_req_wdata : '0;

  always_comb begin
    ram_addr = '0;
    if (if_grant)       ram_addr = if_req_addr[ADDR_W+1:2];
    else if (mem_grant) ram_addr = mem_req_addr[ADDR_W+1:2];
  end

  // Tag of the access whose RAM data arrives next cycle.
  always_comb begin
    tag_d = TAG_NONE;
    if (if_grant)       tag_d = TAG_IF;
    else if (mem_grant) tag_d = mem_req_we ? TAG_MEM_WR : TAG_MEM_RD;
  end

  // Response data is forwarded straight from the RAM in the response cycle and
  // captured so the outputs hold between pulses.
  always_comb begin
    if_resp_valid  = (tag_q == TAG_IF) & ~flush;
    mem_resp_valid = (tag_q == TAG_MEM_RD) | (tag_q == TAG_MEM_WR);
    if_resp_data   = if_data_q;
    mem_resp_data  = mem_data_q;
    if (if_resp_valid)  if_resp_data  = ram_rdata;
    if (mem_resp_valid) mem_resp_data = (tag_q == TAG_MEM_WR) ? '0 : ram_rdata;
    if_data_d  = if_resp_data;
    mem_data_d = mem_resp_data;
  end

  always_comb begin
    starve_d = starve_q;
    if (~if_req_valid | flush | if_grant) starve_d = '0;
    else if (~starve)                     starve_d = starve_q + 4'd1;
  end

  assign starve_cnt = starve_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q      <= TAG_NONE;
      starve_q   <= '0;
      if_data_q  <= '0;
      mem_data_q <= '0;
    end else begin
      tag_q      <= tag_d;
      starve_q   <= starve_d;
      if_data_q  <= if_data_d;
      mem_data_q <= mem_data_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// traffic, checked against a transaction-level model with a shadow memory.
module tb_mem_port_arbiter;

  localparam int ADDR_W   = 11;
  localparam int MAX_WAIT = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req_valid, if_req_ready, if_resp_valid;
  logic [31:0]       if_req_addr, if_resp_data;
  logic              mem_req_valid, mem_req_we, mem_req_ready, mem_resp_valid;
  logic [31:0]       mem_req_addr, mem_req_wdata, mem_resp_data;
  logic              flush;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata = '0;
  logic [3:0]        starve_cnt;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .flush(flush), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, 1-cycle read latency.
  logic [31:0] ram_mem [DEPTH];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  // Reference model: what each port should see, derived from the arbitration rules.
  logic [31:0] sh [DEPTH];
  int          m_starve;
  int          m_pend;        // 0 none, 1 fetch, 2 load, 3 store
  logic [31:0] m_pend_data, m_if_hold, m_mem_hold;
  logic        e_if_g, e_mem_g;
  logic [31:0] e_ifd, e_memd;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  task automatic model_reset();
    m_starve = 0; m_pend = 0; m_pend_data = '0; m_if_hold = '0; m_mem_hold = '0;
  endtask

  // Called at the falling edge: compare everything visible this cycle.
  task automatic check_model();
    logic e_ifv, e_memv;
    e_if_g  = if_req_valid && !flush && (!mem_req_valid || m_starve == MAX_WAIT);
    e_mem_g = mem_req_valid && !e_if_g;
    chk("if_req_ready", 32'(if_req_ready), 32'(e_if_g));
    chk("mem_req_ready", 32'(mem_req_ready), 32'(e_mem_g));
    chk("starve_cnt", 32'(starve_cnt), 32'(m_starve));
    chk("ram_en", 32'(ram_en), 32'(e_if_g || e_mem_g));
    chk("ram_we", 32'(ram_we), 32'(e_mem_g && mem_req_we));
    if (e_if_g)  chk("ram_addr_if", 32'(ram_addr), 32'(widx(if_req_addr)));
    if (e_mem_g) chk("ram_addr_mem", 32'(ram_addr), 32'(widx(mem_req_addr)));
    if (e_mem_g && mem_req_we) chk("ram_wdata", ram_wdata, mem_req_wdata);
    e_ifv  = (m_pend == 1) && !flush;
    e_memv = (m_pend == 2) || (m_pend == 3);
    e_ifd  = e_ifv  ? m_pend_data : m_if_hold;
    e_memd = e_memv ? ((m_pend == 3) ? 32'h0 : m_pend_data) : m_mem_hold;
    chk("if_resp_valid", 32'(if_resp_valid), 32'(e_ifv));
    chk("mem_resp_valid", 32'(mem_resp_valid), 32'(e_memv));
    chk("if_resp_data", if_resp_data, e_ifd);
    chk("mem_resp_data", mem_resp_data, e_memd);
  endtask

  task automatic commit();
    @(posedge clk);
    m_if_hold  = e_ifd;
    m_mem_hold = e_memd;
    m_pend     = 0;
    if (e_if_g) begin
      m_pend = 1; m_pend_data = sh[widx(if_req_addr)];
    end else if (e_mem_g) begin
      if (mem_req_we) begin
        m_pend = 3; sh[widx(mem_req_addr)] = mem_req_wdata;
      end else begin
        m_pend = 2; m_pend_data = sh[widx(mem_req_addr)];
      end
    end
    if (!if_req_valid || flush || e_if_g) m_starve = 0;
    else if (m_starve < MAX_WAIT)         m_starve++;
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    check_model();
    commit();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_ready"}, 32'(if_req_ready), 0);
    chk({tag, "_mem_ready"}, 32'(mem_req_ready), 0);
    chk({tag, "_if_rv"}, 32'(if_resp_valid), 0);
    chk({tag, "_mem_rv"}, 32'(mem_resp_valid), 0);
    chk({tag, "_if_rd"}, if_resp_data, 0);
    chk({tag, "_mem_rd"}, mem_resp_data, 0);
    chk({tag, "_ram_en"}, 32'(ram_en), 0);
    chk({tag, "_ram_we"}, 32'(ram_we), 0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
    chk({tag, "_ram_wdata"}, ram_wdata, 0);
    chk({tag, "_starve"}, 32'(starve_cnt), 0);
  endtask

  task automatic idle_inputs();
    if_req_valid = 0; if_req_addr = '0; mem_req_valid = 0; mem_req_we = 0;
    mem_req_addr = '0; mem_req_wdata = '0; flush = 0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    mem_req_wdata = 32'hA5A5_5A5A;
    for (int i = 0; i < DEPTH; i++) begin
      sh[i] = $urandom; ram_mem[i] = sh[i];
    end
    sh[16] = 32'h2408_0001; ram_mem[16] = 32'h2408_0001;
    model_reset();
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    mem_req_wdata = '0;

    // IF-only fetch from 0x40.
    if_req_valid = 1; if_req_addr = 32'h0000_0040;
    @(negedge clk); check_model();
    chk("t1_ram_addr", 32'(ram_addr), 32'h010);
    chk("t1_ram_en", 32'(ram_en), 1);
    commit();
    if_req_valid = 0;
    @(negedge clk); check_model();
    chk("t1_if_rv", 32'(if_resp_valid), 1);
    chk("t1_if_rd", if_resp_data, 32'h2408_0001);
    chk("t1_mem_rv", 32'(mem_resp_valid), 0);
    commit();

    // IF and MEM load collide; MEM wins, then IF.
    if_req_valid = 1; if_req_addr = 32'h0000_0044;
    mem_req_valid = 1; mem_req_we = 0; mem_req_addr = 32'h0000_0080;
    @(negedge clk); check_model();
    chk("t2_mem_ready", 32'(mem_req_ready), 1);
    chk("t2_if_ready", 32'(if_req_ready), 0);
    commit();
    mem_req_valid = 0;
    @(negedge clk); check_model();
    chk("t2_starve1", 32'(starve_cnt), 1);
    chk("t2_if_ready2", 32'(if_req_ready), 1);
    chk("t2_mem_rv", 32'(mem_resp_valid), 1);
    commit();
    if_req_valid = 0;
    @(negedge clk); check_model();
    chk("t2_if_rv", 32'(if_resp_valid), 1);
    chk("t2_starve0", 32'(starve_cnt), 0);
    commit();

    // Sustained MEM traffic: IF wins after MAX_WAIT denials.
    if_req_valid = 1; if_req_addr = 32'h0000_0048;
    mem_req_valid = 1; mem_req_addr = 32'h0000_0084;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); check_model();
      if (i < MAX_WAIT) begin
        chk("t3_denied", 32'(if_req_ready), 0);
        chk("t3_cnt", 32'(starve_cnt), 32'(i));
      end else if (i == MAX_WAIT) begin
        chk("t3_override_if", 32'(if_req_ready), 1);
        chk("t3_override_mem", 32'(mem_req_ready), 0);
        chk("t3_cnt_sat", 32'(starve_cnt), 32'(MAX_WAIT));
      end else if (i == MAX_WAIT + 1) begin
        chk("t3_cnt_clr", 32'(starve_cnt), 0);
      end
      commit();
    end

    // Store then fetch of the same word returns the stored value.
    if_req_valid = 0;
    mem_req_valid = 1; mem_req_we = 1; mem_req_addr = 32'h0000_0100; mem_req_wdata = 32'hDEAD_BEEF;
    cyc();
    mem_req_valid = 0; mem_req_we = 0;
    if_req_valid = 1; if_req_addr = 32'h0000_0100;
    @(negedge clk); check_model();
    chk("t4_ack_v", 32'(mem_resp_valid), 1);
    chk("t4_ack_d", mem_resp_data, 0);
    commit();
    if_req_valid = 0;
    @(negedge clk); check_model();
    chk("t4_if_rd", if_resp_data, 32'hDEAD_BEEF);
    commit();

    // Flush kills the pending fetch response and blocks IF, not MEM.
    if_req_valid = 1; if_req_addr = 32'h0000_0040;
    cyc();
    flush = 1; mem_req_valid = 1; mem_req_addr = 32'h0000_0080;
    @(negedge clk); check_model();
    chk("t5_if_rv", 32'(if_resp_valid), 0);
    chk("t5_if_ready", 32'(if_req_ready), 0);
    chk("t5_mem_ready", 32'(mem_req_ready), 1);
    commit();
    flush = 0; if_req_valid = 0; mem_req_valid = 0;
    @(negedge clk); check_model();
    chk("t5_mem_rv", 32'(mem_resp_valid), 1);
    chk("t5_starve", 32'(starve_cnt), 0);
    commit();

    // Reset asserted while a fetch is in flight.
    if_req_valid = 1; if_req_addr = 32'h0000_0040;
    cyc();
    #2 rst = 1'b0;
    #1 chk_all_zero("t6");
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    if_req_valid = 0;
    @(negedge clk); check_model();
    chk("t6_no_stale", 32'(if_resp_valid), 0);
    commit();

    // Random traffic with address aliasing in the ignored upper bits.
    for (int i = 0; i < 400; i++) begin
      if_req_valid  = ($urandom_range(0, 3) != 0);
      mem_req_valid = ($urandom_range(0, 2) != 0);
      mem_req_we    = $urandom_range(0, 1) == 1;
      flush         = ($urandom_range(0, 7) == 0);
      if_req_addr   = ($urandom & 32'hFFFF_E003) | 32'($urandom_range(0, 15) << 2);
      mem_req_addr  = ($urandom & 32'hFFFF_E003) | 32'($urandom_range(0, 15) << 2);
      mem_req_wdata = $urandom;
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
